approx_add_pipe: RTL
====================

Name: approx_add_pipe

Overview:
- Parametrised, pipelined lower-part-OR approximate adder; successor to the fixed 8-bit combinational approximate adders in the adder library.
- Operand width, approximate-LSB count and pipeline depth are parameters.
- Exact or approximate mode is selectable per transaction.
- Valid/ready streaming with backpressure, for use in approximate datapaths (accumulators, filters) that need timing closure at wider widths.

Parameters:
- WIDTH, 8, operand width in bits; 2..64.
- APPROX_LSB, 2, number of low bits computed approximately; 0..WIDTH-1. A value of 0 gives an exact adder.
- STAGES, 2, register stages splitting the exact upper carry chain; 1..WIDTH-APPROX_LSB.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_approx  in  1  1 = approximate sum; 0 = exact sum. Sampled with the operands.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH+1  sum, MSB is carry-out.
- out_approx  out  1  mode the result was computed in.

Behaviour:
- Arithmetic, with L = APPROX_LSB:
  - Approx mode: sum[k] = a[k] | b[k] for k < L.
  - Approx mode: carry into bit L = a[L-1] & b[L-1], or 0 when L = 0.
  - Approx mode: bits L..WIDTH are the exact ripple sum of a[W-1:L] + b[W-1:L] + that carry.
  - Exact mode: sum = a + b, WIDTH+1 bits, no truncation.
- Pipeline structure:
  - Upper chain (bits L..W-1) split into STAGES contiguous segments; the first STAGES-1 segments are ceil((W-L)/STAGES) bits wide, the last takes the remainder.
  - The low part and carry-in are computed in stage 0.
  - Each stage registers its partial sum bits, the segment carry, the remaining operand bits, its valid bit and the mode bit.
- Latency: an accepted beat appears on out_* exactly STAGES cycles later if never stalled.
- Throughput: one beat per cycle.
- Handshake:
  - Transfer occurs when valid && ready on the same edge.
  - Stage i loads when stage i is empty or stage i+1 loads (last stage: when out_ready is high). Bubbles therefore collapse.
  - in_ready = stage 0 empty or stage 0 advancing; it is combinational from out_ready through the stage chain.
  - out_valid and out_sum stay stable while out_valid && !out_ready.
  - A full pipe with out_ready low holds STAGES beats; in_ready is 0 in that state.
  - Simultaneous accept and emit in one cycle is legal and keeps full throughput.
- Reset:
  - Asserting rst at any time, including mid-stream, clears all stage valids immediately.
  - Outputs during and after reset: out_valid=0, out_sum=0, out_approx=0.
  - in_ready=1 the cycle after deassertion.
  - In-flight beats are discarded, not flushed.
- in_approx is sampled and carried per beat; mixed modes in flight are legal.

Optional Feature:
- Macro: APPROX_ADD_ERRMON_EN.
- Defined:
  - An exact sum is carried alongside each beat.
  - Extra outputs: out_err (WIDTH+1 bits) = |exact - out_sum|, valid with out_valid.
  - Extra output: err_max (WIDTH+1 bits), a register holding the maximum out_err over all transferred results.
  - err_max updates only on a transfer (out_valid && out_ready); it resets to 0.
  - Extra input: err_clr (1 bit), a synchronous clear of err_max. Clear wins over a same-cycle update.
- Undefined: these ports and their logic are absent.

Decomposition:
- Package approx_add_pkg holds:
  - function seg_width(W, L, S) and the segment-offset function.
  - localparam for the error width, WIDTH+1.
  - the stage payload struct typedef (partial sum, carry, remaining operands, mode).
- One sub-module, approx_add_seg: a combinational exact ripple segment with parameter SEG_W, inputs a, b, cin and outputs s, cout. It is instantiated once per stage.

Test Plan (WIDTH=8, APPROX_LSB=2, STAGES=2 unless stated):
- a=0x03, b=0x01, approx=1 -> out_sum=0x003 after 2 cycles; with the error monitor, out_err=1.
- a=0xFF, b=0xFF, approx=1 -> out_sum=0x1FF; approx=0 -> 0x1FE; with the error monitor, err_max=1.
- Back-to-back stream of 16 random beats with out_ready=1 -> one result per cycle, all matching the reference model, latency 2.
- out_ready=0 for 5 cycles during a stream -> in_ready=0 after 2 beats accepted, out_sum held stable, no beats lost or duplicated after release.
- rst pulsed while 2 beats are in flight -> out_valid=0 immediately; the next beat after release returns its correct sum; err_max=0.
- APPROX_LSB=0, STAGES=4, WIDTH=16: a=0xFFFF, b=0x0001 -> out_sum=0x10000 for both modes, latency 4.

Source files
------------

// File: rtl/approx_add_pkg.sv
// rtl/approx_add_pkg.sv - segment geometry helpers and stage payload for approx_add_pipe
package approx_add_pkg;

   localparam int MAX_W = 64;

   function automatic int err_width(input int w);
      return w + 1;
   endfunction

   function automatic int seg_width(input int w, input int l, input int s);
      return (w - l + s - 1) / s;
   endfunction

   function automatic int seg_offset(input int w, input int l, input int s, input int i);
      return l + i * seg_width(w, l, s);
   endfunction

   // Trailing segments can be short or empty when STAGES does not divide the upper width.
   function automatic int seg_len(input int w, input int l, input int s, input int i);
      int rem;
      rem = w - seg_offset(w, l, s, i);
      if (rem <= 0) return 0;
      if (i == s - 1) return rem;
      return (rem < seg_width(w, l, s)) ? rem : seg_width(w, l, s);
   endfunction

   typedef struct packed {
      logic [MAX_W-1:0] sum;
      logic [MAX_W-1:0] a;
      logic [MAX_W-1:0] b;
      logic             carry;
      logic             approx;
`ifdef APPROX_ADD_ERRMON_EN
      logic [MAX_W:0]   exact;
`endif
   } stage_pld_t;

endpackage

// File: rtl/approx_add_seg.sv
// rtl/approx_add_seg.sv - combinational exact ripple segment
module approx_add_seg #(
   parameter int SEG_W = 4
) (
   input  logic [SEG_W-1:0] a,
   input  logic [SEG_W-1:0] b,
   input  logic             cin,
   output logic [SEG_W-1:0] s,
   output logic             cout
);

   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};

endmodule

// File: rtl/approx_add_pipe.sv
// rtl/approx_add_pipe.sv - pipelined lower-part-OR approximate adder with valid/ready
// Optional error monitor (out_err, err_max, err_clr) enabled by APPROX_ADD_ERRMON_EN.
module approx_add_pipe
   import approx_add_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int APPROX_LSB = 2,
   parameter int STAGES     = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_approx,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic             out_approx
`ifdef APPROX_ADD_ERRMON_EN
   ,
   output logic [WIDTH:0]   out_err,
   output logic [WIDTH:0]   err_max,
   input  logic             err_clr
`endif
);

   localparam int L     = APPROX_LSB;
   localparam int ERR_W = err_width(WIDTH);
   localparam logic [WIDTH-1:0] LO_MASK = WIDTH'((65'd1 << L) - 65'd1);
   localparam logic [WIDTH-1:0] LO_TOP  = LO_MASK ^ (LO_MASK >> 1);

   logic [STAGES-1:0] load;
   logic [STAGES-1:0] vld_vec;
   logic [STAGES-1:0] unused_pld;
   logic [WIDTH-1:0]  lo_exact;
   stage_pld_t        front;
   stage_pld_t        last;
   logic [ERR_W-1:0]  sum_full;

   // A stage stalls only when it and every stage downstream of it hold a beat
   // and the consumer is not ready; computed flat to avoid a bit-to-bit chain.
   always_comb begin : ready_chain
      logic all_full;
      all_full = 1'b1;
      load     = '0;
      for (int i = STAGES - 1; i >= 0; i--) begin
         all_full = all_full & vld_vec[i];
         load[i]  = out_ready | ~all_full;
      end
   end

   assign in_ready = load[0];

   always_comb begin
      lo_exact     = (in_a & LO_MASK) + (in_b & LO_MASK);
      front        = '0;
      front.a[WIDTH-1:0] = in_a;
      front.b[WIDTH-1:0] = in_b;
      front.approx = in_approx;
      if (in_approx) begin
         front.sum[WIDTH-1:0] = (in_a | in_b) & LO_MASK;
         front.carry          = |(in_a & in_b & LO_TOP);
      end else begin
         front.sum[WIDTH-1:0] = lo_exact & LO_MASK;
         front.carry          = lo_exact[L];
      end
`ifdef APPROX_ADD_ERRMON_EN
      front.exact[WIDTH:0] = {1'b0, in_a} + {1'b0, in_b};
`endif
   end

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      localparam int OFF = seg_offset(WIDTH, L, STAGES, i);
      localparam int LEN = seg_len(WIDTH, L, STAGES, i);

      stage_pld_t src;
      stage_pld_t pld_d;
      stage_pld_t pld_q;
      logic       src_vld;
      logic       vld_q;

      if (i == 0) begin : g_src0
         assign src     = front;
         assign src_vld = in_valid;
      end else begin : g_srcn
         assign src     = g_stage[i-1].pld_q;
         assign src_vld = g_stage[i-1].vld_q;
      end

      if (LEN > 0) begin : g_seg
         logic [LEN-1:0] seg_s;
         logic           seg_c;

         approx_add_seg #(.SEG_W(LEN)) u_seg (
            .a   (src.a[OFF +: LEN]),
            .b   (src.b[OFF +: LEN]),
            .cin (src.carry),
            .s   (seg_s),
            .cout(seg_c)
         );

         always_comb begin
            pld_d                  = src;
            pld_d.sum[OFF +: LEN]  = seg_s;
            pld_d.carry            = seg_c;
         end
      end else begin : g_pass
         assign pld_d = src;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= 1'b0;
            pld_q <= '0;
         end else if (load[i]) begin
            vld_q <= src_vld;
            if (src_vld) pld_q <= pld_d;
         end
      end

      assign vld_vec[i]    = vld_q;
      assign unused_pld[i] = ^pld_q;
   end

   assign last       = g_stage[STAGES-1].pld_q;
   assign sum_full   = {last.carry, last.sum[WIDTH-1:0]};
   assign out_valid  = vld_vec[STAGES-1];
   assign out_sum    = sum_full;
   assign out_approx = last.approx;

`ifdef APPROX_ADD_ERRMON_EN
   logic [ERR_W-1:0] exact_q;

   assign exact_q = last.exact[WIDTH:0];

   // Approximate results can overshoot the exact sum, so the error is a magnitude.
   always_comb begin
      out_err = '0;
      if (exact_q >= sum_full) out_err = exact_q - sum_full;
      else                     out_err = sum_full - exact_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_max <= '0;
      end else if (err_clr) begin
         err_max <= '0;
      end else if (out_valid && out_ready && (out_err > err_max)) begin
         err_max <= out_err;
      end
   end
`endif

endmodule
